// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 width codes, FSM encoding,
// byte-enable patterns and the per-access legality/lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Stores only take the signed width codes; unsigned codes are load-only.
  function automatic logic access_ok(input logic [2:0] f3, input logic we, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_BYTE0 << a;
      2'b01:   be = a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath memory instruction into a single
// request/ack bus transaction with lane steering, fault detection and timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] raw_q, raw_d;
  logic        bus_err_q, bus_err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;

  logic        access, launch;
  logic [31:0] ext_data;

  assign access = mem_read ^ mem_write;
  assign launch = (state_q == ST_IDLE) && access && access_ok(funct3, mem_write, addr[1:0]);
  assign fault  = (state_q == ST_IDLE) && ((mem_read & mem_write) || (access && !launch));
  assign stall  = launch || (state_q == ST_REQ);

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    raw_d       = raw_q;
    bus_err_d   = bus_err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d     = ST_REQ;
          addr_lo_d   = addr[1:0];
          funct3_d    = funct3;
          we_d        = mem_write;
          cnt_d       = 8'd0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = byte_enable(funct3, addr[1:0]);
          bus_wdata_d = mem_write ? lane_data(funct3, wdata) : 32'd0;
        end
      end
      ST_REQ: begin
        // An ack on the last allowed cycle still counts as a completion.
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          state_d     = ST_DONE;
          cnt_d       = 8'd0;
          raw_d       = bus_ack ? bus_rdata : 32'd0;
          bus_err_d   = ~bus_ack;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_wdata_d = 32'd0;
          bus_be_d    = BE_NONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        raw_d     = 32'd0;
        bus_err_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'd0;
      funct3_q    <= 3'd0;
      we_q        <= 1'b0;
      cnt_q       <= 8'd0;
      raw_q       <= 32'd0;
      bus_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= BE_NONE;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      raw_q       <= raw_d;
      bus_err_q   <= bus_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
    end
  end

  load_extend u_load_extend (
    .word_i    (raw_q),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (ext_data)
  );

  assign rdata     = ((state_q == ST_DONE) && !we_q && !bus_err_q) ? ext_data : 32'd0;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked
// every cycle against a transaction-level expectation model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall, fault, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_fault, exp_bus_err, exp_bus_req, exp_bus_we;
  logic [31:0] exp_rdata, exp_bus_addr, exp_bus_wdata;
  logic [3:0]  exp_bus_be;

  // Observations from the most recent access, used by the literal checks.
  int          last_stall_cycles, last_req_cycles;
  logic        last_fault, last_done_err, last_bwe;
  logic [31:0] last_done_rdata, last_bwdata;
  logic [3:0]  last_be;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] f3, input bit is_store, input logic [31:0] a);
    int size;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (is_store && f3[2]) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_lane(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return 32'(d[7:0]) * 32'h01010101;
      2'd1:    return 32'(d[15:0]) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (8 * int'(a[1:0]));
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_fault = 1'b0; exp_bus_err = 1'b0; exp_bus_req = 1'b0;
    exp_bus_we = 1'b0; exp_rdata = 32'd0; exp_bus_addr = 32'd0; exp_bus_wdata = 32'd0;
    exp_bus_be = 4'd0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(exp_stall));
      cmp("fault", 32'(fault), 32'(exp_fault));
      cmp("bus_err", 32'(bus_err), 32'(exp_bus_err));
      cmp("bus_req", 32'(bus_req), 32'(exp_bus_req));
      cmp("bus_we", 32'(bus_we), 32'(exp_bus_we));
      cmp("bus_addr", bus_addr, exp_bus_addr);
      cmp("bus_wdata", bus_wdata, exp_bus_wdata);
      cmp("bus_be", 32'(bus_be), 32'(exp_bus_be));
      cmp("rdata", rdata, exp_rdata);
    end
  end

  // One memory instruction; entered just after a rising edge with the DUT idle.
  // ack_at is the 1-based REQ cycle carrying the ack; anything else never acks.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input bit fixed_word, input logic [31:0] word);
    bit          legal, timed_out;
    logic [31:0] cap;
    legal = (rd ^ wr) && ref_legal(f3, wr, a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    set_idle_exp();
    exp_stall = legal;
    exp_fault = (rd && wr) || ((rd ^ wr) && !legal);
    last_stall_cycles = 0; last_req_cycles = 0; last_done_rdata = 32'd0;
    last_done_err = 1'b0; last_be = 4'd0; last_bwdata = 32'd0; last_bwe = 1'b0;
    @(negedge clk);
    last_fault = fault;
    if (stall) last_stall_cycles++;
    @(posedge clk); #1;
    if (legal) begin
      mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      cap = 32'd0; timed_out = 1'b1;
      for (int k = 1; k <= TO; k++) begin
        set_idle_exp();
        exp_stall = 1'b1; exp_bus_req = 1'b1; exp_bus_we = wr;
        exp_bus_addr = {a[31:2], 2'b00}; exp_bus_be = ref_be(f3, a);
        exp_bus_wdata = wr ? ref_lane(f3, wd) : 32'd0;
        bus_rdata = fixed_word ? word : $urandom;
        bus_ack = (k == ack_at);
        @(negedge clk);
        last_req_cycles++;
        if (stall) last_stall_cycles++;
        last_be = bus_be; last_bwdata = bus_wdata; last_bwe = bus_we;
        @(posedge clk); #1;
        if (k == ack_at) begin
          cap = bus_rdata; timed_out = 1'b0;
          break;
        end
      end
      set_idle_exp();
      exp_bus_err = timed_out;
      exp_rdata = (timed_out || wr) ? 32'd0 : ref_load(cap, a, f3);
      bus_ack = 1'($urandom); bus_rdata = $urandom;
      @(negedge clk);
      last_done_rdata = rdata; last_done_err = bus_err;
      if (stall) last_stall_cycles++;
      @(posedge clk); #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    set_idle_exp();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // LW with ack on the second REQ cycle.
    run_access(1, 0, 3'd2, 32'h100, 32'd0, 2, 1, 32'hDEADBEEF);
    cmp("lw_stall_cycles", 32'(last_stall_cycles), 32'd3);
    cmp("lw_rdata", last_done_rdata, 32'hDEADBEEF);

    run_access(1, 0, 3'd0, 32'h103, 32'd0, 1, 1, 32'h80FFFFFF);
    cmp("lb_rdata", last_done_rdata, 32'hFFFFFF80);
    run_access(1, 0, 3'd4, 32'h103, 32'd0, 1, 1, 32'h80FFFFFF);
    cmp("lbu_rdata", last_done_rdata, 32'h00000080);

    run_access(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 1, 0, 32'd0);
    cmp("sh_be", 32'(last_be), 32'h0000000C);
    cmp("sh_wdata", last_bwdata, 32'hABCDABCD);
    cmp("sh_we", 32'(last_bwe), 32'd1);

    run_access(1, 0, 3'd2, 32'h101, 32'd0, 1, 0, 32'd0);
    cmp("mis_fault", 32'(last_fault), 32'd1);
    cmp("mis_stall_cycles", 32'(last_stall_cycles), 32'd0);
    cmp("mis_req_cycles", 32'(last_req_cycles), 32'd0);

    run_access(1, 0, 3'd2, 32'h300, 32'd0, 0, 0, 32'd0);
    cmp("to_req_cycles", 32'(last_req_cycles), 32'd4);
    cmp("to_bus_err", 32'(last_done_err), 32'd1);
    cmp("to_rdata", last_done_rdata, 32'd0);

    // Reset asserted while a request is outstanding.
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0;
    set_idle_exp();
    exp_stall = 1'b1; exp_bus_req = 1'b1; exp_bus_addr = 32'h400; exp_bus_be = 4'hF;
    @(negedge clk); #1;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    cmp("rst_bus_req", 32'(bus_req), 32'd0);
    cmp("rst_stall", 32'(stall), 32'd0);
    cmp("rst_bus_addr", bus_addr, 32'd0);
    cmp("rst_bus_be", 32'(bus_be), 32'd0);
    set_idle_exp();
    @(negedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    run_access(1, 0, 3'd2, 32'h500, 32'd0, 1, 1, 32'h0BADF00D);
    cmp("post_rst_rdata", last_done_rdata, 32'h0BADF00D);

    for (int n = 0; n < 400; n++) begin
      int          r;
      bit          rd, wr;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      rd = (r == 0) || (r >= 2 && r <= 5);
      wr = (r == 0) || (r >= 6);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_access(rd, wr, 3'($urandom), a, $urandom, int'($urandom_range(1, TO + 1)), 0, 32'd0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles spent waiting for bus_ack (range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-low reset (asserted at 0).
REQ-004 mem_read  in  1  SHALL request a load for the current instruction.
REQ-005 mem_write  in  1  SHALL request a store for the current instruction.
REQ-006 funct3  in  3  SHALL carry the load/store width and sign code (Instr[14:12]).
REQ-007 addr  in  32  SHALL carry the byte address from the datapath (Mem_WrAddr).
REQ-008 wdata  in  32  SHALL carry the store data from the datapath (Mem_WrData).
REQ-009 rdata  out  32  SHALL return the final extended load value to the datapath (ReadData).
REQ-010 stall  out  1  SHALL hold the PC and register-file write while high.
REQ-011 fault  out  1  SHALL flag a misaligned access or an illegal funct3 value.
REQ-012 bus_err  out  1  SHALL flag a bus timeout.
REQ-013 bus_req, bus_we  out  1 each  SHALL form the memory request and its write qualifier.
REQ-014 bus_addr  out  32  SHALL carry the word-aligned address {addr[31:2],2'b00}.
REQ-015 bus_wdata  out  32; bus_be  out  4  SHALL carry the lane-replicated store data and the byte enables.
REQ-016 bus_ack  in  1; bus_rdata  in  32  SHALL carry the memory completion and the read word.

Function
REQ-017 FSM states SHALL be IDLE, REQ and DONE.
REQ-018 IDLE: an access is mem_read XOR mem_write; if it is legal, the block SHALL drive stall=1 combinationally, latch addr[1:0], funct3, wdata and we, and move to REQ.
REQ-019 Legal widths SHALL be B(000), H(001), W(010), BU(100) and HU(101); stores accept only 000, 001 and 010.
REQ-020 A misaligned access (H with addr[0]=1, W with addr[1:0]!=0), an illegal funct3, or mem_read and mem_write both high SHALL give fault=1 and stall=0 for that cycle, no bus request, rdata=0, and the FSM stays in IDLE.
REQ-021 REQ: bus_req SHALL be a registered 1 with stable bus_addr, bus_we, bus_be and bus_wdata, stall=1, and the timeout counter increments each cycle.
REQ-022 bus_ack in REQ SHALL capture bus_rdata, clear the counter and move to DONE.
REQ-023 If the counter reaches TIMEOUT_CYCLES without an ack, the block SHALL move to DONE with bus_err=1 and rdata=0.
REQ-024 DONE: stall=0, rdata valid, bus_req=0, and the FSM SHALL return unconditionally to IDLE (no relaunch of the same instruction).
REQ-025 Minimum latency: the access cycle, one REQ cycle with ack, then DONE, giving 3 cycles per memory instruction.
REQ-026 Store lanes:
  - SB: be=1<<addr[1:0], byte replicated 4x.
  - SH: be=0011 when addr[1]=0, else 1100; half replicated 2x.
  - SW: be=1111.
REQ-027 Loads SHALL select the byte or half by the latched addr[1:0]; B and H are sign-extended, BU and HU are zero-extended, and W passes through.
REQ-028 bus_ack outside REQ SHALL be ignored.
REQ-029 bus_err SHALL be high only during DONE after a timeout.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE, with bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, bus_err=0 and counter=0, including mid-REQ.
REQ-031 The first access after reset release SHALL start from IDLE normally.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 width codes, the FSM state encoding and the byte-enable constants.
REQ-033 Sub-module load_extend (combinational lane select and sign/zero extend) SHALL be instantiated once.

Verification
REQ-034 LW addr=0x100, ack after 2 REQ cycles, bus_rdata=0xDEADBEEF -> stall high 3 cycles, rdata=0xDEADBEEF in DONE.
REQ-035 LB addr=0x103, bus_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; LBU, same stimulus -> 0x00000080.
REQ-036 SH addr=0x202, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-037 LW addr=0x101 -> fault=1, stall=0, bus_req never asserted.
REQ-038 Access with no ack, TIMEOUT_CYCLES=4 -> 4 REQ cycles, then DONE with bus_err=1, rdata=0.
REQ-039 Reset pulled low during REQ -> bus_req=0 asynchronously; after release, a new LW completes normally.
